// File: rtl/match_logger_pkg.sv
// ============================================================================
// Module      : match_logger_pkg
// Description : Shared constants and entry packing helper for match_logger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package match_logger_pkg;

    localparam int GAP_W   = 5;
    localparam int S_W     = 3;
    localparam int ENTRY_W = 8;
    localparam int S_LSB   = 5;
    localparam int GAP_LSB = 0;

    // Gap saturates rather than wraps so long idle stretches read as "very long".
    localparam logic [GAP_W-1:0] GAP_MAX = 5'd31;

    // Build a log record: detector state in the upper field, gap in the lower field.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [S_W-1:0]   s,
                                                      input logic [GAP_W-1:0] g);
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[S_LSB +: S_W]     = s;
        e[GAP_LSB +: GAP_W] = g;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/match_fifo.sv
// ============================================================================
// Module      : match_fifo
// Description : DEPTH x WIDTH first-word-fall-through FIFO, async reset.
//               Occupancy is tracked explicitly; full/empty come from it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_w;
    logic             do_pop_w;

    // Qualify strobes locally: a pop on empty is ignored, a push on full only
    // lands when a pop frees the head slot on the same edge.
    always_comb begin
        do_pop_w  = pop_i & ~empty_o;
        do_push_w = push_i & (~full_o | do_pop_w);
        wr_ptr_d  = do_push_w ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_w  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d   = level_q;
        if (do_push_w && !do_pop_w) begin
            level_d = level_q + LW'(1);
        end else if (!do_push_w && do_pop_w) begin
            level_d = level_q - LW'(1);
        end
    end

    // Pointer, occupancy and storage registers; power-of-two depth wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (do_push_w) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/match_logger.sv
// ============================================================================
// Module      : match_logger
// Description : Logs rising edges of a detector flag with the detector state
//               and the cycle gap since the previous event into a FWFT FIFO.
//               Keeps a saturating event count and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_logger
    import match_logger_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    F,
    input  logic [2:0]              S,
    input  logic                    pop,
    output logic [CNT_W-1:0]        count,
    output logic [7:0]              rdata,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    logic               f_q;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               event_w;
    logic               pop_ok_w;
    logic               push_w;
    logic [ENTRY_W-1:0] entry_w;
    logic               empty_w;
    logic               full_w;

    // Edge detect, gap/count update and push gating.
    always_comb begin
        event_w    = F & ~f_q;
        pop_ok_w   = pop & ~empty_w;
        push_w     = event_w & (~full_w | pop_ok_w);
        entry_w    = pack_entry(S, gap_q);
        gap_d      = gap_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (event_w) begin
            gap_d = '0;
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
            if (full_w && !pop_ok_w) begin
                overflow_d = 1'b1;
            end
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            f_q        <= 1'b0;
            gap_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            f_q        <= F;
            gap_q      <= gap_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    match_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push_i  (push_w),
        .pop_i   (pop_ok_w),
        .wdata_i (entry_w),
        .rdata_o (rdata),
        .level_o (level),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_match_logger.sv
// ============================================================================
// Module      : tb_match_logger
// Description : Self-checking bench for match_logger with an entry scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_match_logger;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             CLK;
    logic             RESET;
    logic             F;
    logic [2:0]       S;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [7:0]       rdata;
    logic             empty;
    logic             full;
    logic [2:0]       level;
    logic             overflow;

    int total;
    int bad;

    // Reference state
    logic [7:0] sb [$];
    logic       m_fq;
    logic [4:0] m_gap;
    int         m_count;
    logic       m_ovf;

    match_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .F        (F),
        .S        (S),
        .pop      (pop),
        .count    (count),
        .rdata    (rdata),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_clear();
        sb.delete();
        m_fq    = 1'b0;
        m_gap   = 5'd0;
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    // Drive one edge's inputs, advance past the edge, update the reference.
    task automatic tick(input logic f, input logic [2:0] s, input logic p);
        logic       ev;
        logic       pok;
        logic       fl;
        logic [7:0] e;
        logic [7:0] dropped;
        F   = f;
        S   = s;
        pop = p;
        ev  = f & ~m_fq;
        pok = p & (sb.size() != 0);
        fl  = (sb.size() == DEPTH);
        e   = {s, m_gap};
        @(posedge CLK);
        if (pok) dropped = sb.pop_front();
        if (ev) begin
            if (fl && !pok) m_ovf = 1'b1;
            else            sb.push_back(e);
            if (m_count != 255) m_count++;
        end
        if (ev)                 m_gap = 5'd0;
        else if (m_gap != 5'd31) m_gap = m_gap + 5'd1;
        m_fq = f;
        #1;
        F   = 1'b0;
        pop = 1'b0;
    endtask

    task automatic do_reset();
        F     = 1'b0;
        S     = 3'b000;
        pop   = 1'b0;
        RESET = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d expected 0", level); end
        total++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0)
            begin bad++; $display("FAIL reset_flags: got e=%0b f=%0b o=%0b expected e=1 f=0 o=0", empty, full, overflow); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %0h expected 00", rdata); end
    endtask

    task automatic test_two_events();
        logic [7:0] exp;
        do_reset();
        tick(0, 3'b010, 0);
        tick(0, 3'b010, 0);
        tick(1, 3'b010, 0);
        total++; if (level !== 3'd1 || count !== 8'd1)
            begin bad++; $display("FAIL t1_latency: got level=%0d count=%0d expected 1 1", level, count); end
        tick(0, 3'b010, 0);
        tick(0, 3'b010, 0);
        tick(0, 3'b010, 0);
        tick(1, 3'b010, 0);
        total++; if (count !== 8'd2) begin bad++; $display("FAIL t1_count: got %0d expected 2", count); end
        total++; if (level !== 3'd2) begin bad++; $display("FAIL t1_level: got %0d expected 2", level); end
        total++; if (rdata !== 8'b010_00010) begin bad++; $display("FAIL t1_entry0: got %b expected 01000010", rdata); end
        exp = sb[0];
        total++; if (rdata !== exp) begin bad++; $display("FAIL t1_sb0: got %h expected %h", rdata, exp); end
        tick(0, 3'b010, 1);
        total++; if (rdata !== 8'b010_00011) begin bad++; $display("FAIL t1_entry1: got %b expected 01000011", rdata); end
    endtask

    task automatic test_held_high();
        do_reset();
        tick(0, 3'b101, 0);
        tick(0, 3'b101, 0);
        tick(0, 3'b101, 0);
        for (int i = 0; i < 5; i++) tick(1, 3'b101, 0);
        tick(0, 3'b101, 0);
        total++; if (count !== 8'd1 || level !== 3'd1)
            begin bad++; $display("FAIL t2_single: got count=%0d level=%0d expected 1 1", count, level); end
        total++; if (rdata !== 8'b101_00011) begin bad++; $display("FAIL t2_entry: got %b expected 10100011", rdata); end
    endtask

    task automatic test_overflow_drain();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1, 3'(i + 1), 0);
            tick(0, 3'(i + 1), 0);
        end
        total++; if (full !== 1'b1 || overflow !== 1'b1)
            begin bad++; $display("FAIL t3_flags: got full=%0b ovf=%0b expected 1 1", full, overflow); end
        total++; if (count !== 8'd5 || level !== 3'd4)
            begin bad++; $display("FAIL t3_count_level: got %0d %0d expected 5 4", count, level); end
        total++; if (rdata !== 8'b001_00000) begin bad++; $display("FAIL t3_first: got %b expected 00100000", rdata); end
        for (int i = 0; i < 4; i++) begin
            exp = sb[0];
            total++; if (rdata !== exp) begin bad++; $display("FAIL t3_pop%0d: got %h expected %h", i, rdata, exp); end
            tick(0, 3'b000, 1);
        end
        total++; if (empty !== 1'b1 || rdata !== 8'h00 || level !== 3'd0)
            begin bad++; $display("FAIL t3_empty: got e=%0b rdata=%h level=%0d expected 1 00 0", empty, rdata, level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t3_sticky: got %0b expected 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] old2;
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, 3'(i + 1), 0);
            tick(0, 3'(i + 1), 0);
        end
        old2 = sb[1];
        tick(1, 3'b111, 1);
        total++; if (level !== 3'd4 || full !== 1'b1)
            begin bad++; $display("FAIL t4_level: got %0d full=%0b expected 4 1", level, full); end
        total++; if (rdata !== old2) begin bad++; $display("FAIL t4_head: got %h expected %h", rdata, old2); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t4_ovf: got %0b expected 0", overflow); end
        total++; if (sb[3] !== 8'b111_00001) begin bad++; $display("FAIL t4_model_tail: got %b expected 11100001", sb[3]); end
        for (int i = 0; i < 4; i++) begin
            exp = sb[0];
            total++; if (rdata !== exp) begin bad++; $display("FAIL t4_pop%0d: got %h expected %h", i, rdata, exp); end
            tick(0, 3'b000, 1);
        end
    endtask

    task automatic test_gap_saturate();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 40; i++) tick(0, 3'b011, 0);
        tick(1, 3'b011, 0);
        tick(0, 3'b011, 0);
        tick(1, 3'b110, 0);
        total++; if (rdata !== 8'b011_11111) begin bad++; $display("FAIL t5_sat: got %b expected 01111111", rdata); end
        exp = sb[0];
        total++; if (rdata !== exp) begin bad++; $display("FAIL t5_sb0: got %h expected %h", rdata, exp); end
        tick(0, 3'b000, 1);
        total++; if (rdata !== 8'b110_00001) begin bad++; $display("FAIL t5_gap1: got %b expected 11000001", rdata); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 3'b001, 0);
            tick(0, 3'b001, 0);
        end
        total++; if (level !== 3'd3) begin bad++; $display("FAIL t6_pre: got %0d expected 3", level); end
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        total++; if (count !== 8'd0 || level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || rdata !== 8'h00)
            begin bad++; $display("FAIL t6_async: got c=%0d l=%0d e=%0b o=%0b r=%h expected 0 0 1 0 00",
                                  count, level, empty, overflow, rdata); end
        #1;
        RESET = 1'b0;
        model_clear();
        tick(0, 3'b000, 1);
        total++; if (level !== 3'd0 || empty !== 1'b1 || count !== 8'd0)
            begin bad++; $display("FAIL t6_pop_empty: got l=%0d e=%0b c=%0d expected 0 1 0", level, empty, count); end
        tick(1, 3'b100, 1);
        total++; if (level !== 3'd1 || rdata !== 8'b100_00001)
            begin bad++; $display("FAIL t6_push_empty_pop: got l=%0d r=%b expected 1 10000001", level, rdata); end
    endtask

    task automatic test_count_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            tick(1, 3'b000, 1);
            tick(0, 3'b000, 1);
        end
        total++; if (count !== 8'd255) begin bad++; $display("FAIL cnt_sat: got %0d expected 255", count); end
        total++; if (int'(count) !== m_count) begin bad++; $display("FAIL cnt_model: got %0d expected %0d", count, m_count); end
        total++; if (int'(level) !== sb.size()) begin bad++; $display("FAIL cnt_level: got %0d expected %0d", level, sb.size()); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b1;
        F     = 1'b0;
        S     = 3'b000;
        pop   = 1'b0;
        model_clear();
        test_reset();
        test_two_events();
        test_held_high();
        test_overflow_drain();
        test_full_push_pop();
        test_gap_saturate();
        test_async_reset();
        test_count_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/match_logger.md
Name: match_logger

Overview:
- Downstream consumer of the sequence-detector FSM (machine_d); takes its detection flag F and 3-bit state S.
- Counts detection events and timestamps each one with the gap since the previous event.
- Buffers {S, gap} records in a small FWFT FIFO for a host to pop at its own pace.
- Provides a saturating total count and a sticky overflow flag.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 8, width of total detection counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous active-high reset
F  in  1  detection flag from the detector FSM
S  in  3  detector state, captured with each event
pop  in  1  host read strobe, acts on rising CLK
count  out  CNT_W  total detections, saturating
rdata  out  8  head entry {S[2:0], gap[4:0]}; 0 when empty
empty  out  1  FIFO empty
full  out  1  FIFO holds DEPTH entries
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: event arrived while full and no pop accepted

Behaviour:
- Clock/reset: one clock CLK, rising edge; RESET asynchronous active-high. While RESET=1, all registers clear immediately with no clock edge needed.
- Reset values: count=0, level=0, empty=1, full=0, overflow=0, rdata=0, F_q=0, gap=0.
- Event detect:
  - F_q registers F each edge.
  - event = F & ~F_q, i.e. the F rising edge as sampled at CLK.
  - F held high for N cycles yields one event.
- Gap counter (5 bits):
  - Without an event: gap <= gap+1, saturating at 31.
  - With an event: the current gap value is written into the entry, then gap <= 0.
- count: +1 per event, saturating at 2^CNT_W-1, never wraps.
- Entry: {S sampled at the event edge, gap}; S occupies bits [7:5].
- FIFO:
  - Reads are first-word-fall-through: rdata is combinational from the head, and 0 when empty.
  - push = event & (~full | pop_ok), where pop_ok = pop & ~empty.
  - pop with empty=1 is ignored, with no state change.
  - event with empty=1 and pop=1: the push is accepted, the pop is ignored, and level becomes 1.
  - event with full=1 and pop=1: the head is dropped, the new entry goes to the tail, level stays DEPTH, and overflow is unaffected.
  - event with full=1 and pop=0: the entry is discarded, overflow <= 1 (sticky until RESET), and count still increments.
- Pointers wrap modulo DEPTH. Full/empty are derived from level, not from pointer equality.
- Latency:
  - An event sampled on edge k is visible on rdata/level/count after edge k (same edge update).
  - A pop on edge k exposes the next entry after edge k.
- Reset mid-operation discards all entries and the gap history. Behaviour after release is identical to power-up.

Decomposition:
- Package match_logger_pkg: GAP_W=5, GAP_MAX=31, S_W=3, ENTRY_W=8, field offsets S_LSB=5 and GAP_LSB=0.
- Sub-module match_fifo: parameterised DEPTH×ENTRY_W synchronous FWFT FIFO with async reset, push/pop/level/full/empty. Simultaneous push+pop is legal when full.
- Top level holds edge detect, gap counter, count, overflow and push gating.

Test Plan:
1. Reset, S=3'b010, F high only at edge 3 and edge 7 → count=2, entries {010,00010} then {010,00011}, level=2.
2. F held high for 5 consecutive edges → count=1, level=1, gap field = cycles since reset at the rise.
3. DEPTH=4: 5 separated events, no pops → full=1, overflow=1, count=5, level=4. Then 4 pops return the first four entries in order, after which empty=1 and rdata=0.
4. full=1, event coincident with pop → level stays 4, head advances to old entry 2, new entry at tail, overflow stays 0 (if previously 0).
5. 40 idle cycles then an event → gap field=31. Next event 2 cycles later → gap=1.
6. RESET pulsed while CLK low with 3 entries held → count=0, empty=1, overflow=0, level=0 before any CLK edge. pop on empty afterwards → no change.
